round_sched: RTL and testbench
==============================

// Module: round_sched
// PURPOSE
// - Shares one combinational `round` datapath between two requesters.
//   Port 0 is the multiplier normalizer; port 1 is the adder/FMA normalizer.
// - Round-robin arbitration, valid/ready handshakes, two-stage pipeline:
//   S1 is the operand register, S2 is the result register.
// - Every result is tagged with the id of the requester that issued it.
// PARAMETERS
// - INTn  32  width of the unrounded significand sigIn
// - NEXP   8  exponent field width; exponent buses are NEXP+2 bits, signed
// - NSIG  23  stored fraction bits; sigOut is NSIG+1 bits
// - NRAS      rounding-attribute vector width, taken from ieee-754-flags.vh
// PORTS
// - clk              in   1        the block's single clock
// - rst              in   1        synchronous, active-high reset
// - in_valid[1:0]    in   2        request valid, one bit per requester
// - in_ready[1:0]    out  2        request accepted this cycle (grant)
// - in_neg[1:0]      in   2        sign of each requester's operand
// - in_exp0/in_exp1  in   NEXP+2   signed unrounded exponent
// - in_sig0/in_sig1  in   INTn     unrounded significand, MSB-aligned
// - in_ra0/in_ra1    in   NRAS     one-hot rounding attribute
// - out_valid        out  1        result valid
// - out_ready        in   1        downstream accepts the result
// - out_id           out  1        requester that issued this result
// - out_exp          out  NEXP+2   rounded exponent (carry-adjusted)
// - out_sig          out  NSIG+1   rounded significand
// - out_inexact      out  1        some truncated bit was nonzero
// - out_ra_err       out  1        in_ra was not one-hot; RNE was substituted
// BEHAVIOUR
// - Reset values:
//   - all outputs 0, so in_ready=0 during reset
//   - S1 and S2 valid flags 0
//   - rr_ptr=0, meaning port 0 is preferred first
//   - on the first cycle after reset, in_ready follows the arbitration rule
// - Reset mid-operation: in-flight S1/S2 contents are dropped and no output
//   is produced for them.
// - Handshakes:
//   - s2_rdy = !s2_v || out_ready
//   - s1_rdy = !s1_v || s2_rdy
//   - A transfer occurs on cycles where valid && ready.
// - Arbitration (combinational, only when s1_rdy = 1):
//   - Only one requester valid: that requester is granted.
//   - Both valid: grant port rr_ptr, then set rr_ptr to the other port.
//   - rr_ptr changes only on a grant that resolved a contention.
//   - At most one in_ready bit is 1 in any cycle.
// - Requester contract: once in_valid is asserted it is held, with stable
//   operands, until granted. The bench asserts this.
// - S1 capture: {id, neg, exp, sig, ra} of the winner; s1_v=1.
//   - If no grant and S1 advances, s1_v=0.
//   - If S1 does not advance, S1 holds.
// - S1->S2:
//   - `round` evaluates S1 combinationally.
//   - S2 captures {id, expOut, sigOut, inexact, ra_err} when s2_rdy.
// - Latency: grant in cycle N gives out_valid in cycle N+2 when out_ready
//   has stayed 1.
// - Throughput: one result per cycle with no stalls; full stall holds both
//   stages.
// - Back-pressure: out_ready=0 with S2 full holds S2 stable. S1 also holds if
//   full, and in_ready drops to 0.
// - ra check: if S1.ra is not exactly one-hot, pass an ra with
//   roundTiesToEven set to `round`, and set ra_err=1 in S2.
// - Width rules:
//   - out_exp = expIn + carry, signed NEXP+2, no saturation.
//   - Overflow and underflow are the packer's job.
//   - On carry, out_sig is renormalized inside `round`.
// - Simultaneous events:
//   - S2 drain, S1 advance and a new grant can all happen in one cycle.
//   - Both ports valid in every cycle alternate 0,1,0,1...
// STRUCTURE
// - Constants come from ieee-754-flags.vh: NRAS, bit indices roundTiesToEven,
//   roundTowardZero, roundTowardPositive, roundTowardNegative, EMIN.
// - Submodule: one `round` instance (U_rnd), parameters INTn/NEXP/NSIG passed
//   through.
// - Local logic only: arbiter, S1/S2 registers, one-hot check.
// - No other submodules.
// TESTING
// - Config for all cases: INTn=32, NEXP=8, NSIG=23.
// - Single request:
//   - stimulus: port0 exp=10, sig=32'hFFFF_FF80, RNE, neg=0
//   - response: 2 cycles later out_exp=11, out_sig=24'h800000, inexact=1,
//     id=0
// - Tie, even:
//   - stimulus: port1 exp=0, sig=32'h8000_0080, RNE
//   - response: out_sig=24'h800000, inexact=1
//   - same operand with roundTowardPositive, neg=0: out_sig=24'h800001
//   - same operand with roundTowardNegative, neg=0: out_sig=24'h800000
// - Contention:
//   - stimulus: both ports valid for 6 cycles, out_ready=1
//   - response: grants 0,1,0,1,0,1; out_id follows 2 cycles later; no
//     cycle has both in_ready bits set
// - Back-pressure:
//   - stimulus: out_ready=0 for 5 cycles with port0 streaming
//   - response: exactly 2 results buffered, in_ready=0 from the 3rd cycle,
//     S2 unchanged; release yields in-order results with no loss or
//     duplication
// - Bad ra:
//   - stimulus: ra with two bits set, sig=32'h8000_0180
//   - response: out_ra_err=1, RNE applied, out_sig=24'h800002
// - Reset mid-flight:
//   - stimulus: assert rst with S1 and S2 full
//   - response: next cycle out_valid=0, rr_ptr=0, no stale result after
//     release

Source files
------------

// File: rtl/round_sched_pkg.sv
// rtl/round_sched_pkg.sv - shared constants and helpers for the round scheduler
package round_sched_pkg;

  // Rounding-attribute vector: one bit per IEEE-754 rounding direction.
  localparam int NRAS                = 5;
  localparam int roundTiesToEven     = 0;
  localparam int roundTowardZero     = 1;
  localparam int roundTowardPositive = 2;
  localparam int roundTowardNegative = 3;
  localparam int roundTiesToAway     = 4;

  // Identifies a requester; also the encoding of the round-robin pointer.
  typedef enum logic [0:0] {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // True when exactly one rounding attribute is selected.
  function automatic logic ra_is_onehot(input logic [NRAS-1:0] ra);
    return $countones(ra) == 1;
  endfunction

endpackage

// File: rtl/round_sched_round.sv
// rtl/round_sched_round.sv - combinational significand rounder with carry renormalization
module round_sched_round
  import round_sched_pkg::*;
#(
  parameter int INTn = 32,
  parameter int NEXP = 8,
  parameter int NSIG = 23
) (
  input  logic                 neg_i,
  input  logic signed [NEXP+1:0] exp_i,
  input  logic [INTn-1:0]      sig_i,
  input  logic [NRAS-1:0]      ra_i,
  output logic signed [NEXP+1:0] exp_o,
  output logic [NSIG:0]        sig_o,
  output logic                 inexact_o
);

  // Bits below the kept significand; the first of them is the guard bit.
  localparam int NDROP = INTn - NSIG - 1;

  logic [NSIG:0]   kept;
  logic            guard;
  logic            sticky;
  logic            inexact;
  logic            inc;
  logic [NSIG+1:0] sum;

  // Decide the increment from guard/sticky/lsb and the selected direction, then renormalize on carry.
  always_comb begin
    kept    = sig_i[INTn-1 -: NSIG+1];
    guard   = sig_i[NDROP-1];
    sticky  = |sig_i[NDROP-2:0];
    inexact = guard | sticky;
    inc     = 1'b0;
    if (ra_i[roundTiesToEven])          inc = guard & (sticky | kept[0]);
    else if (ra_i[roundTowardZero])     inc = 1'b0;
    else if (ra_i[roundTowardPositive]) inc = inexact & ~neg_i;
    else if (ra_i[roundTowardNegative]) inc = inexact & neg_i;
    else if (ra_i[roundTiesToAway])     inc = guard;
    sum = {1'b0, kept} + {{(NSIG+1){1'b0}}, inc};
    if (sum[NSIG+1]) begin
      sig_o = sum[NSIG+1:1];
      exp_o = exp_i + {{(NEXP+1){1'b0}}, 1'b1};
    end else begin
      sig_o = sum[NSIG:0];
      exp_o = exp_i;
    end
    inexact_o = inexact;
  end

endmodule

// File: rtl/round_sched.sv
// rtl/round_sched.sv - two-requester round-robin front end for a shared two-stage rounder
module round_sched
  import round_sched_pkg::*;
#(
  parameter int INTn = 32,
  parameter int NEXP = 8,
  parameter int NSIG = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             in_valid,
  output logic [1:0]             in_ready,
  input  logic [1:0]             in_neg,
  input  logic signed [NEXP+1:0] in_exp0,
  input  logic signed [NEXP+1:0] in_exp1,
  input  logic [INTn-1:0]        in_sig0,
  input  logic [INTn-1:0]        in_sig1,
  input  logic [NRAS-1:0]        in_ra0,
  input  logic [NRAS-1:0]        in_ra1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_id,
  output logic signed [NEXP+1:0] out_exp,
  output logic [NSIG:0]          out_sig,
  output logic                   out_inexact,
  output logic                   out_ra_err
);

  // S1: operand register
  logic                   s1_v_q, s1_id_q, s1_neg_q;
  logic signed [NEXP+1:0] s1_exp_q;
  logic [INTn-1:0]        s1_sig_q;
  logic [NRAS-1:0]        s1_ra_q;
  // S2: result register
  logic                   s2_v_q, s2_id_q, s2_inexact_q, s2_ra_err_q;
  logic signed [NEXP+1:0] s2_exp_q;
  logic [NSIG:0]          s2_sig_q;

  port_e                  rr_ptr_q, rr_ptr_d;
  logic                   s1_rdy, s2_rdy;
  logic [1:0]             gnt;
  logic                   ra_ok;
  logic [NRAS-1:0]        rnd_ra;
  logic signed [NEXP+1:0] rnd_exp;
  logic [NSIG:0]          rnd_sig;
  logic                   rnd_inexact;

  // Handshake readiness and round-robin grant; the pointer only flips when it broke a tie.
  always_comb begin
    s2_rdy   = !s2_v_q || out_ready;
    s1_rdy   = !s1_v_q || s2_rdy;
    gnt      = 2'b00;
    rr_ptr_d = rr_ptr_q;
    if (!rst && s1_rdy) begin
      case (in_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          gnt      = (rr_ptr_q == PORT0) ? 2'b01 : 2'b10;
          rr_ptr_d = (rr_ptr_q == PORT0) ? PORT1 : PORT0;
        end
        default: gnt = 2'b00;
      endcase
    end
    in_ready = gnt;
  end

  // Malformed rounding attributes fall back to round-to-nearest-even.
  always_comb begin
    ra_ok  = ra_is_onehot(s1_ra_q);
    rnd_ra = '0;
    if (ra_ok) rnd_ra = s1_ra_q;
    else       rnd_ra[roundTiesToEven] = 1'b1;
  end

  round_sched_round #(
    .INTn(INTn),
    .NEXP(NEXP),
    .NSIG(NSIG)
  ) U_rnd (
    .neg_i    (s1_neg_q),
    .exp_i    (s1_exp_q),
    .sig_i    (s1_sig_q),
    .ra_i     (rnd_ra),
    .exp_o    (rnd_exp),
    .sig_o    (rnd_sig),
    .inexact_o(rnd_inexact)
  );

  // S1 captures the granted requester's operands, empties when it advances without a new grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_id_q  <= 1'b0;
      s1_neg_q <= 1'b0;
      s1_exp_q <= '0;
      s1_sig_q <= '0;
      s1_ra_q  <= '0;
    end else if (s1_rdy) begin
      s1_v_q <= |gnt;
      if (|gnt) begin
        s1_id_q  <= gnt[1];
        s1_neg_q <= gnt[1] ? in_neg[1] : in_neg[0];
        s1_exp_q <= gnt[1] ? in_exp1 : in_exp0;
        s1_sig_q <= gnt[1] ? in_sig1 : in_sig0;
        s1_ra_q  <= gnt[1] ? in_ra1 : in_ra0;
      end
    end
  end

  // S2 takes the rounded S1 contents whenever the downstream slot is free or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q       <= 1'b0;
      s2_id_q      <= 1'b0;
      s2_exp_q     <= '0;
      s2_sig_q     <= '0;
      s2_inexact_q <= 1'b0;
      s2_ra_err_q  <= 1'b0;
    end else if (s2_rdy) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_id_q      <= s1_id_q;
        s2_exp_q     <= rnd_exp;
        s2_sig_q     <= rnd_sig;
        s2_inexact_q <= rnd_inexact;
        s2_ra_err_q  <= !ra_ok;
      end
    end
  end

  // Round-robin pointer; port 0 is preferred after reset.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= PORT0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign out_valid   = s2_v_q;
  assign out_id      = s2_id_q;
  assign out_exp     = s2_exp_q;
  assign out_sig     = s2_sig_q;
  assign out_inexact = s2_inexact_q;
  assign out_ra_err  = s2_ra_err_q;

endmodule

// File: tb/tb_round_sched.sv
// tb/tb_round_sched.sv - self-checking bench for round_sched
module tb_round_sched;
  import round_sched_pkg::*;

  localparam int EW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    in_valid, in_ready, in_neg;
  logic [EW-1:0] in_exp0, in_exp1;
  logic [31:0]   in_sig0, in_sig1;
  logic [4:0]    in_ra0, in_ra1;
  logic          out_valid, out_ready, out_id, out_inexact, out_ra_err;
  logic [EW-1:0] out_exp;
  logic [23:0]   out_sig;

  round_sched #(.INTn(32), .NEXP(8), .NSIG(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_neg(in_neg),
    .in_exp0(in_exp0), .in_exp1(in_exp1), .in_sig0(in_sig0), .in_sig1(in_sig1),
    .in_ra0(in_ra0), .in_ra1(in_ra1), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_exp(out_exp), .out_sig(out_sig), .out_inexact(out_inexact),
    .out_ra_err(out_ra_err)
  );

  typedef struct {
    logic id; logic [EW-1:0] e; logic [23:0] s; logic inx; logic err; int vis;
  } exp_t;

  typedef struct {
    logic port; logic neg; logic [EW-1:0] e; logic [31:0] s; logic [4:0] ra;
    logic [EW-1:0] xe; logic [23:0] xs; logic xinx; logic xerr;
  } vec_t;

  exp_t q[$];
  int   nvec = 0, nerr = 0, cyc = 0, n_m = 0;
  logic ptr_m = 1'b0;
  logic contract_on = 1'b0;
  logic [1:0] pv = 2'b00, pg = 2'b00;
  logic [47:0] pop_op [2];

  logic [1:0]    gnt_s;
  logic          ov_s, oid_s, oinx_s, oerr_s;
  logic [EW-1:0] oexp_s;
  logic [23:0]   osig_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference rounding from the arithmetic definition of each direction.
  function automatic void ref_round(input logic neg, input logic [EW-1:0] e, input logic [31:0] s,
                                    input logic [4:0] ra, output logic [EW-1:0] eo,
                                    output logic [23:0] so, output logic inx, output logic err);
    int up, rem, r, inc, mode;
    up   = int'(s >> 8);
    rem  = int'(s & 32'hFF);
    err  = ($countones(ra) != 1);
    mode = roundTiesToEven;
    if (!err) for (int i = 0; i < NRAS; i++) if (ra[i]) mode = i;
    case (mode)
      roundTiesToEven:     inc = (rem > 128 || (rem == 128 && up % 2 == 1)) ? 1 : 0;
      roundTowardZero:     inc = 0;
      roundTowardPositive: inc = (rem != 0 && !neg) ? 1 : 0;
      roundTowardNegative: inc = (rem != 0 && neg) ? 1 : 0;
      default:             inc = (rem >= 128) ? 1 : 0;
    endcase
    r  = up + inc;
    eo = e;
    if (r == 16777216) begin
      r  = r / 2;
      eo = e + 10'd1;
    end
    so  = 24'(r);
    inx = (rem != 0);
  endfunction

  function automatic logic [47:0] op_now(input logic p);
    return p ? {in_neg[1], in_exp1, in_sig1, in_ra1} : {in_neg[0], in_exp0, in_sig0, in_ra0};
  endfunction

  // Sampled at the falling edge: checks grant and output against the capacity-2 FIFO model.
  task automatic monitor();
    logic [1:0] eg;
    logic s1r, p, exp_ov;
    exp_t it;
    gnt_s = in_ready; ov_s = out_valid; oid_s = out_id; oinx_s = out_inexact;
    oerr_s = out_ra_err; oexp_s = out_exp; osig_s = out_sig;
    if (rst) begin
      chk("in_ready_rst", 32'(in_ready), 32'd0);
      q.delete(); n_m = 0; ptr_m = 1'b0;
    end else begin
      if (contract_on) for (int k = 0; k < 2; k++)
        if (pv[k] && !pg[k])
          assert (in_valid[k] && op_now(k[0]) == pop_op[k])
            else $error("requester contract broken on port %0d", k);
      s1r = (n_m < 2) || out_ready;
      eg  = 2'b00;
      if (s1r) begin
        if (in_valid == 2'b01) eg = 2'b01;
        else if (in_valid == 2'b10) eg = 2'b10;
        else if (in_valid == 2'b11) begin
          eg = ptr_m ? 2'b10 : 2'b01;
          ptr_m = ~ptr_m;
        end
      end
      chk("in_ready", 32'(in_ready), 32'(eg));
      if (eg != 2'b00) begin
        p = eg[1];
        ref_round(in_neg[p], p ? in_exp1 : in_exp0, p ? in_sig1 : in_sig0, p ? in_ra1 : in_ra0,
                  it.e, it.s, it.inx, it.err);
        it.id = p; it.vis = cyc + 2;
        q.push_back(it);
        n_m++;
      end
      exp_ov = (q.size() > 0) && (q[0].vis <= cyc);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (out_valid && out_ready && exp_ov) begin
        it = q.pop_front();
        n_m--;
        chk("out_id", 32'(out_id), 32'(it.id));
        chk("out_exp", 32'(out_exp), 32'(it.e));
        chk("out_sig", 32'(out_sig), 32'(it.s));
        chk("out_inexact", 32'(out_inexact), 32'(it.inx));
        chk("out_ra_err", 32'(out_ra_err), 32'(it.err));
      end
    end
    pv = in_valid; pg = in_ready;
    pop_op[0] = op_now(1'b0); pop_op[1] = op_now(1'b1);
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic p, input logic neg, input logic [EW-1:0] e,
                        input logic [31:0] s, input logic [4:0] ra);
    in_neg[p] = neg;
    if (p) begin in_exp1 = e; in_sig1 = s; in_ra1 = ra; end
    else   begin in_exp0 = e; in_sig0 = s; in_ra0 = ra; end
  endtask

  task automatic run_vec(input vec_t v);
    set_op(v.port, v.neg, v.e, v.s, v.ra);
    in_valid = v.port ? 2'b10 : 2'b01;
    out_ready = 1'b1;
    tick();
    chk("vec_grant", 32'(gnt_s), v.port ? 32'd2 : 32'd1);
    in_valid = 2'b00;
    tick();
    chk("vec_early", 32'(ov_s), 32'd0);
    tick();
    chk("vec_valid", 32'(ov_s), 32'd1);
    chk("vec_id", 32'(oid_s), 32'(v.port));
    chk("vec_exp", 32'(oexp_s), 32'(v.xe));
    chk("vec_sig", 32'(osig_s), 32'(v.xs));
    chk("vec_inexact", 32'(oinx_s), 32'(v.xinx));
    chk("vec_ra_err", 32'(oerr_s), 32'(v.xerr));
  endtask

  vec_t tbl[11];
  logic [1:0] pend;
  logic [23:0] held, got[$];
  int k, cnt;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 10'd10,  32'hFFFF_FF80, 5'b00001, 10'd11,  24'h800000, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 10'd0,   32'h8000_0080, 5'b00001, 10'd0,   24'h800000, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 10'd0,   32'h8000_0080, 5'b00100, 10'd0,   24'h800001, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 10'd0,   32'h8000_0080, 5'b01000, 10'd0,   24'h800000, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 10'h3FD, 32'h8000_0080, 5'b01000, 10'h3FD, 24'h800001, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 10'd5,   32'h8000_0180, 5'b00101, 10'd5,   24'h800002, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 10'd7,   32'h1234_5600, 5'b00100, 10'd7,   24'h123456, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 10'd1,   32'hFFFF_FFFF, 5'b00010, 10'd1,   24'hFFFFFF, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 10'd2,   32'h8000_0180, 5'b00000, 10'd2,   24'h800002, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 10'd3,   32'h8000_0080, 5'b10000, 10'd3,   24'h800001, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 10'h3FF, 32'hFFFF_FF80, 5'b00001, 10'd0,   24'h800000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 2'b00; in_neg = 2'b00; out_ready = 1'b1;
    in_exp0 = '0; in_exp1 = '0; in_sig0 = '0; in_sig1 = '0; in_ra0 = 5'b00001; in_ra1 = 5'b00001;
    in_valid = 2'b11;
    repeat (3) tick();
    chk("rst_out_valid", 32'(ov_s), 32'd0);
    chk("rst_out_sig", 32'(osig_s), 32'd0);
    chk("rst_out_exp", 32'(oexp_s), 32'd0);
    in_valid = 2'b00;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(tbl[i]);

    // contention: strict alternation starting at port 0, ids follow two cycles later
    set_op(1'b0, 1'b0, 10'd1, 32'h8000_0000, 5'b00001);
    set_op(1'b1, 1'b0, 10'd2, 32'hC000_0000, 5'b00001);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 6) ? 2'b11 : 2'b00;
      tick();
      if (i < 6) chk("cont_grant", 32'(gnt_s), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont_onehot", 32'($countones(gnt_s) <= 1), 32'd1);
      if (i >= 2) chk("cont_id", 32'(oid_s), 32'((i - 2) % 2));
    end

    // back-pressure: two results buffered, then ordered release
    k = 0; out_ready = 1'b0; in_valid = 2'b01;
    set_op(1'b0, 1'b0, 10'(k), 32'h8000_0000 | 32'(k << 8), 5'b00001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready", 32'(gnt_s), (i < 2) ? 32'd1 : 32'd0);
      if (gnt_s[0]) begin
        k++;
        set_op(1'b0, 1'b0, 10'(k), 32'h8000_0000 | 32'(k << 8), 5'b00001);
      end
      if (i == 2) held = osig_s;
      if (i >= 2) begin
        chk("bp_hold_valid", 32'(ov_s), 32'd1);
        chk("bp_hold_sig", 32'(osig_s), 32'(held));
      end
    end
    chk("bp_buffered", 32'(k), 32'd2);
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      in_valid = (k < 4) ? 2'b01 : 2'b00;
      tick();
      if (ov_s) got.push_back(osig_s);
      if (gnt_s[0]) begin
        k++;
        set_op(1'b0, 1'b0, 10'(k), 32'h8000_0000 | 32'(k << 8), 5'b00001);
      end
    end
    chk("bp_count", 32'(got.size()), 32'd4);
    foreach (got[j]) chk("bp_order", 32'(got[j]), 32'h800000 + 32'(j));

    // reset with both stages full and the pointer moved to port 1
    out_ready = 1'b0; in_valid = 2'b01;
    tick();
    in_valid = 2'b11;
    tick();
    rst = 1'b1; in_valid = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_out_valid", 32'(ov_s), 32'd0);
    in_valid = 2'b11; out_ready = 1'b1;
    tick();
    chk("mid_rst_ptr", 32'(gnt_s), 32'd1);
    in_valid = 2'b00; cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ov_s) cnt++;
    end
    chk("mid_rst_no_stale", 32'(cnt), 32'd1);

    // randomized traffic against the model
    pend = 2'b00; contract_on = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(1, 0) == 1) begin
          logic [31:0] s;
          logic [4:0]  ra;
          s = $urandom();
          case ($urandom_range(3, 0))
            0: s[7:0] = 8'h80;
            1: s[7:0] = 8'h00;
            2: s[7:0] = 8'h7F;
            default: ;
          endcase
          if ($urandom_range(7, 0) == 0) s[31:8] = 24'hFFFFFF;
          if ($urandom_range(7, 0) == 0) ra = 5'($urandom());
          else ra = 5'(1 << $urandom_range(4, 0));
          set_op(p[0], 1'($urandom()), 10'($urandom()), s, ra);
          pend[p] = 1'b1;
        end
      end
      in_valid = pend;
      out_ready = ($urandom_range(9, 0) < 7);
      tick();
      pend = pend & ~gnt_s;
    end
    contract_on = 1'b0;
    in_valid = 2'b00; out_ready = 1'b1;
    repeat (6) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
